// File: rtl/cache_miss_rate_calc_if.sv
// Request/result bundle for the miss-rate divider: start plus counter operands in,
// busy/done handshake and fixed-point rate, percentage and status flags out.
interface cache_miss_rate_calc_if #(
  parameter int CNT_W  = 12,
  parameter int FRAC_W = 12
);
  logic              start;
  logic [CNT_W-1:0]  misses_in;
  logic [CNT_W-1:0]  accesses_in;
  logic              busy;
  logic              done;
  logic [FRAC_W-1:0] miss_rate;
  logic [6:0]        miss_rate_pct;
  logic              div_zero;
  logic              saturated;

  modport master (
    output start, misses_in, accesses_in,
    input  busy, done, miss_rate, miss_rate_pct, div_zero, saturated
  );

  modport slave (
    input  start, misses_in, accesses_in,
    output busy, done, miss_rate, miss_rate_pct, div_zero, saturated
  );
endinterface

// File: rtl/cache_miss_rate_calc.sv
// Miss rate = misses/accesses as unsigned Q0.FRAC_W via restoring division; done FRAC_W+2
// edges after start (2 on zero/saturation); start is ignored while busy, results hold until next done.
module cache_miss_rate_calc #(
  parameter int CNT_W  = 12,
  parameter int FRAC_W = 12
) (
  input logic                    clk,
  input logic                    reset,
  cache_miss_rate_calc_if.slave  bus
);
  localparam int CNT_BITS = $clog2(FRAC_W + 1);
  localparam int PW       = FRAC_W + 7;

  typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, FINISH} state_t;

  typedef struct packed {
    logic [FRAC_W-1:0] rate;
    logic [6:0]        pct;
    logic              div_zero;
    logic              saturated;
  } result_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    m, a;
  logic [CNT_W:0]      rem;
  logic [CNT_W:0]      t;
  logic                t_ge;
  logic [FRAC_W-1:0]   q;
  logic [CNT_BITS-1:0] cnt;
  logic                pend_zero, pend_sat;
  logic                done_q;
  result_t             res_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CHECK;
      CHECK:   state_d = (a == '0 || m >= a) ? FINISH : DIVIDE;
      DIVIDE:  if (cnt == CNT_BITS'(1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rem < a always holds, so the shifted remainder fits CNT_W+1 bits
  always_comb begin
    t    = rem << 1;
    t_ge = (t >= {1'b0, a});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m         <= '0;
      a         <= '0;
      rem       <= '0;
      q         <= '0;
      cnt       <= '0;
      pend_zero <= 1'b0;
      pend_sat  <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            m <= bus.misses_in;
            a <= bus.accesses_in;
          end
        end
        CHECK: begin
          pend_zero <= 1'b0;
          pend_sat  <= 1'b0;
          if (a == '0) begin
            q         <= '0;
            pend_zero <= 1'b1;
          end else if (m >= a) begin
            q        <= '1;
            pend_sat <= 1'b1;
          end else begin
            rem <= {1'b0, m};
            q   <= '0;
            cnt <= CNT_BITS'(FRAC_W);
          end
        end
        DIVIDE: begin
          rem <= t_ge ? (t - {1'b0, a}) : t;
          q   <= {q[FRAC_W-2:0], t_ge};
          cnt <= cnt - CNT_BITS'(1);
        end
        FINISH: begin
          res_q.rate      <= q;
          res_q.div_zero  <= pend_zero;
          res_q.saturated <= pend_sat;
          // saturated quotient would floor to 99%, so it is pinned to 100
          if (pend_sat)       res_q.pct <= 7'd100;
          else if (pend_zero) res_q.pct <= 7'd0;
          else                res_q.pct <= 7'(({7'b0, q} * PW'(100)) >> FRAC_W);
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.miss_rate     = res_q.rate;
  assign bus.miss_rate_pct = res_q.pct;
  assign bus.div_zero      = res_q.div_zero;
  assign bus.saturated     = res_q.saturated;
endmodule

// File: tb/tb_cache_miss_rate_calc.sv
// Bench for cache_miss_rate_calc: transaction-level reference model checked every cycle,
// plus directed cases with hand-computed results.
module tb_cache_miss_rate_calc;
  logic clk;
  logic reset;

  cache_miss_rate_calc_if #(.CNT_W(12), .FRAC_W(12)) bus ();

  cache_miss_rate_calc #(.CNT_W(12), .FRAC_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, results appear a fixed number of edges later
  int edge_cnt  = 0;
  int acc_edge  = 0;
  bit mdl_valid = 0;
  bit mdl_busy  = 0;
  int remain    = 0;
  int am, aa;
  int p_rate, p_pct, p_dz, p_sat;
  int e_rate, e_pct, e_dz, e_sat, e_done;

  always @(posedge clk) begin
    if (reset) begin
      mdl_valid = 1;
      mdl_busy  = 0;
      remain    = 0;
      e_rate = 0; e_pct = 0; e_dz = 0; e_sat = 0; e_done = 0;
    end else if (mdl_valid) begin
      e_done = 0;
      if (mdl_busy) begin
        remain--;
        if (remain == 0) begin
          mdl_busy = 0;
          e_rate = p_rate; e_pct = p_pct; e_dz = p_dz; e_sat = p_sat;
          e_done = 1;
        end
      end else if (bus.start) begin
        am = int'(bus.misses_in);
        aa = int'(bus.accesses_in);
        acc_edge = edge_cnt;
        if (aa == 0) begin
          p_rate = 0; p_pct = 0; p_dz = 1; p_sat = 0; remain = 2;
        end else if (am >= aa) begin
          p_rate = 4095; p_pct = 100; p_dz = 0; p_sat = 1; remain = 2;
        end else begin
          p_rate = (am * 4096) / aa;
          p_pct  = (p_rate * 100) / 4096;
          p_dz = 0; p_sat = 0; remain = 14;
        end
        mdl_busy = 1;
      end
    end
    edge_cnt++;
  end

  always @(negedge clk) begin
    if (mdl_valid) begin
      check("busy",      bus.busy,          mdl_busy);
      check("done",      bus.done,          e_done);
      check("miss_rate", bus.miss_rate,     e_rate);
      check("pct",       bus.miss_rate_pct, e_pct);
      check("div_zero",  bus.div_zero,      e_dz);
      check("saturated", bus.saturated,     e_sat);
    end
  end

  task automatic wait_done(input bit chg, output bit seen, output int dedge);
    seen  = 0;
    dedge = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (chg && i == 1) begin
        bus.misses_in   = 12'd9;
        bus.accesses_in = 12'd9;
      end
      if (bus.done === 1'b1) begin
        seen  = 1;
        dedge = edge_cnt - 1;
        break;
      end
    end
    check("done_within_budget", seen, 1);
  endtask

  task automatic run_one(input int mi, input int ai, input bit chg,
                         input int er, input int ep, input int edz, input int esat, input int elat);
    int  s_edge, dedge;
    bit  seen;
    bus.misses_in   = 12'(mi);
    bus.accesses_in = 12'(ai);
    bus.start       = 1;
    s_edge = edge_cnt;
    @(negedge clk);
    bus.start = 0;
    check("busy_after_start", bus.busy, 1);
    wait_done(chg, seen, dedge);
    if (seen) begin
      check("latency",       dedge - s_edge,    elat);
      check("lit_miss_rate", bus.miss_rate,     er);
      check("lit_pct",       bus.miss_rate_pct, ep);
      check("lit_div_zero",  bus.div_zero,      edz);
      check("lit_saturated", bus.saturated,     esat);
    end
  endtask

  initial begin
    int  s_edge, d0, d1, d2;
    bit  seen;
    clk             = 0;
    reset           = 1;
    bus.start       = 0;
    bus.misses_in   = '0;
    bus.accesses_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_rate", bus.miss_rate, 0);
    reset = 0;
    @(negedge clk);

    run_one(1, 4, 0, 1024, 25, 0, 0, 14);
    run_one(3, 7, 1, 1755, 42, 0, 0, 14);
    run_one(0, 0, 0, 0, 0, 1, 0, 2);
    run_one(5, 5, 0, 4095, 100, 0, 1, 2);

    // start held high: back-to-back computations every 15 cycles
    bus.misses_in   = 12'd2;
    bus.accesses_in = 12'd8;
    bus.start       = 1;
    s_edge = edge_cnt;
    wait_done(0, seen, d0);
    check("held_rate0", bus.miss_rate, 1024);
    wait_done(0, seen, d1);
    check("held_rate1", bus.miss_rate, 1024);
    wait_done(0, seen, d2);
    bus.start = 0;
    check("held_rate2", bus.miss_rate, 1024);
    check("held_first", d0 - s_edge, 14);
    check("held_gap1",  d1 - d0, 15);
    check("held_gap2",  d2 - d1, 15);

    // reset mid-divide at edge 6
    bus.misses_in   = 12'd1;
    bus.accesses_in = 12'd3;
    bus.start       = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (5) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_rate", bus.miss_rate, 0);
    check("midrst_pct",  bus.miss_rate_pct, 0);
    check("midrst_flags", {bus.div_zero, bus.saturated}, 0);
    reset = 0;
    @(negedge clk);
    run_one(0, 9, 0, 0, 0, 0, 0, 14);

    // randomized traffic, including starts while busy and rare resets
    for (int c = 0; c < 3000; c++) begin
      int av, mv;
      @(negedge clk);
      case ($urandom_range(0, 3))
        0:       av = $urandom_range(0, 3);
        1:       av = $urandom_range(1, 40);
        default: av = $urandom_range(0, 4095);
      endcase
      mv = $urandom_range(0, (av + 2 > 4095) ? 4095 : av + 2);
      bus.misses_in   = 12'(mv);
      bus.accesses_in = 12'(av);
      bus.start       = ($urandom_range(0, 3) == 0);
      reset           = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    bus.start = 0;
    reset     = 0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
